trace_scheduler: RTL

// Frame-level controller for the ray tracer. Holds a double-buffered view set (player, facing, vplane):
// the host writes the pending set at any time, and it is copied to the active set only at VBLANK entry.
// The block drives tracer enable for one trace pass per frame and gates tracer stores into the trace buffer.
// It detects pass completion and flags an overrun if the pass does not finish before the next visible frame.

---
 rtl/trace_scheduler_pkg.sv | 34 +++
 rtl/trace_scheduler_view_regs.sv | 59 +++++
 rtl/trace_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/trace_scheduler_pkg.sv
// trace_scheduler_pkg: shared widths, default frame timing and the scheduler state type.
`default_nettype none

package trace_scheduler_pkg;

  // View set packing: {playerX, playerY, facingX, facingY, vplaneX, vplaneY}, each Q6.10.
  localparam int VIEW_W   = 96;
  localparam int FRAME_W  = 11;
  localparam int WDOG_W   = 16;
  localparam int RASTER_W = 10;
  localparam int COL_W    = 10;

  localparam int H_TOTAL_DEF    = 800;
  localparam int V_VIEW_DEF     = 480;
  localparam int V_TOTAL_DEF    = 525;
  localparam int TRACE_COLS_DEF = 640;
  localparam int WATCHDOG_DEF   = 36000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } sched_state_e;

  // Watchdog increment that holds at all-ones instead of wrapping.
  function automatic logic [WDOG_W-1:0] sat_inc(input logic [WDOG_W-1:0] v);
    return (&v) ? v : v + WDOG_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_scheduler_view_regs.sv
// view_regs: pending/active double buffer of the view set with dirty and cfg_valid flags.
`default_nettype none

module view_regs
  import trace_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en_i,
  input  logic [VIEW_W-1:0] wr_view_i,
  input  logic              latch_i,
  output logic [VIEW_W-1:0] active_o,
  output logic              dirty_o,
  output logic              cfg_valid_o
);

  logic [VIEW_W-1:0] pending_q, pending_d;
  logic [VIEW_W-1:0] active_q, active_d;
  logic              dirty_q, dirty_d;
  logic              cfg_valid_q, cfg_valid_d;

  always_comb begin
    pending_d   = pending_q;
    active_d    = active_q;
    dirty_d     = dirty_q;
    cfg_valid_d = cfg_valid_q;
    if (latch_i && dirty_q) begin
      active_d    = pending_q;
      dirty_d     = 1'b0;
      cfg_valid_d = 1'b1;
    end
    // The scheduler refuses writes during the latch cycle, so a write never races the copy.
    if (wr_en_i) begin
      pending_d = wr_view_i;
      dirty_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q   <= '0;
      active_q    <= '0;
      dirty_q     <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      active_q    <= active_d;
      dirty_q     <= dirty_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  assign active_o    = active_q;
  assign dirty_o     = dirty_q;
  assign cfg_valid_o = cfg_valid_q;

endmodule

`default_nettype wire

// File: rtl/trace_scheduler.sv
// trace_scheduler: per-frame trace pass controller with view double-buffering,
// store gating, completion pulse and sticky overrun on deadline/watchdog abort.
`default_nettype none

module trace_scheduler
  import trace_scheduler_pkg::*;
#(
  parameter int H_TOTAL    = H_TOTAL_DEF,
  parameter int V_VIEW     = V_VIEW_DEF,
  parameter int V_TOTAL    = V_TOTAL_DEF,
  parameter int TRACE_COLS = TRACE_COLS_DEF,
  parameter int WATCHDOG   = WATCHDOG_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [RASTER_W-1:0] hpos,
  input  logic [RASTER_W-1:0] vpos,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [VIEW_W-1:0]   upd_view,
  output logic                tr_enable,
  output logic [VIEW_W-1:0]   tr_view,
  output logic [FRAME_W-1:0]  tr_frame,
  input  logic                tr_store,
  input  logic [COL_W-1:0]    tr_column,
  output logic                buf_we,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam logic [RASTER_W-1:0] H_LAST    = RASTER_W'(H_TOTAL - 1);
  localparam logic [RASTER_W-1:0] V_VIEW_C  = RASTER_W'(V_VIEW);
  localparam logic [RASTER_W-1:0] V_LAST    = RASTER_W'(V_TOTAL - 1);
  localparam logic [COL_W-1:0]    COL_LAST  = COL_W'(TRACE_COLS - 1);
  localparam logic [WDOG_W-1:0]   WDOG_LAST = WDOG_W'(WATCHDOG - 1);

  sched_state_e        state_q, state_d;
  logic                tr_enable_q, tr_enable_d;
  logic [FRAME_W-1:0]  tr_frame_q, tr_frame_d;
  logic                overrun_q, overrun_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;

  logic raster_ok;
  logic vblank_start;
  logic deadline;
  logic upd_fire;
  logic latch;
  logic dirty;
  logic cfg_valid;
  logic last_store;

  // Out-of-range raster coordinates never produce frame events.
  assign raster_ok    = (hpos <= H_LAST) && (vpos <= V_LAST);
  assign vblank_start = raster_ok && (vpos == V_VIEW_C) && (hpos == '0);
  assign deadline     = raster_ok && (vpos == V_LAST) && (hpos == '0);

  assign upd_ready  = (state_q != ST_LATCH);
  assign upd_fire   = upd_valid && upd_ready;
  assign latch      = (state_q == ST_LATCH);
  assign last_store = tr_store && (tr_column == COL_LAST);

  view_regs u_view_regs (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en_i     (upd_fire),
    .wr_view_i   (upd_view),
    .latch_i     (latch),
    .active_o    (tr_view),
    .dirty_o     (dirty),
    .cfg_valid_o (cfg_valid)
  );

  always_comb begin
    state_d    = state_q;
    tr_frame_d = tr_frame_q;
    overrun_d  = overrun_q;
    wdog_d     = wdog_q;
    unique case (state_q)
      ST_IDLE: begin
        if (vblank_start) begin
          state_d    = ST_LATCH;
          tr_frame_d = tr_frame_q + FRAME_W'(1);
        end
      end
      ST_LATCH: begin
        wdog_d  = '0;
        // A view latched this very cycle counts as a valid configuration.
        state_d = (cfg_valid || dirty) ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        wdog_d = sat_inc(wdog_q);
        if (last_store) begin
          state_d = ST_DONE;
        end else if (deadline || (wdog_q == WDOG_LAST)) begin
          state_d = ST_ABORT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        overrun_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    tr_enable_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tr_enable_q <= 1'b0;
      tr_frame_q  <= '0;
      overrun_q   <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      tr_enable_q <= tr_enable_d;
      tr_frame_q  <= tr_frame_d;
      overrun_q   <= overrun_d;
      wdog_q      <= wdog_d;
    end
  end

  // Stores are dropped outside RUN, and during the reset cycle itself.
  assign buf_we     = (state_q == ST_RUN) && tr_store && reset_n;
  assign busy       = (state_q == ST_LATCH) || (state_q == ST_RUN);
  assign frame_done = (state_q == ST_DONE);
  assign tr_enable  = tr_enable_q;
  assign tr_frame   = tr_frame_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire
